fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
// Parametrised fetch stage with a DEPTH-entry prefetch queue between instruction ROM and decode.
// Fetches one big-endian word per cycle from the byte ROM and stores {pc, instruction} entries in a FIFO.
// Decode drains the FIFO through a valid/ready handshake, so decode back-pressure never re-reads the ROM.
// A redirect from execute flushes the FIFO and restarts fetch at the target address.
// PARAMETERS
// WIDTH     Constants::WIDTH     address/instruction width
// BYTE      Constants::BYTE      ROM byte width; WIDTH == 4*BYTE
// ROM_SIZE  Constants::ROM_SIZE  ROM depth in bytes
// DEPTH     4                    FIFO entries; power of two, >= 2
// RESET_PC  0                    fetch PC after reset; word aligned
// PORTS
// clk              in   1               clock, all state updates on rising edge
// rst              in   1               synchronous reset, active-high
// rom              in   BYTE x ROM_SIZE instruction ROM, read combinationally
// redirect         in   1               flush queue and restart fetch at redirect_target
// redirect_target  in   WIDTH           new fetch PC; bits [1:0] ignored (forced 0)
// out_ready        in   1               decode accepts head entry this cycle
// out_valid        out  1               head entry valid (queue not empty)
// out_pc           out  WIDTH           PC of head entry; 0 when empty
// out_instruction  out  WIDTH           instruction of head entry; 0 when empty
// occupancy        out  $clog2(DEPTH+1) entries currently held
// fetch_fault      out  1               sticky: fetch PC + 3 >= ROM_SIZE, fetch halted
// BEHAVIOUR
// - Reset (rst=1 at edge): fetch PC <= RESET_PC, queue emptied, fetch_fault <= 0. Every output reads 0.
//   Reset wins over redirect and every other input.
// - Word read: {rom[pc], rom[pc+1], rom[pc+2], rom[pc+3]}, with rom[pc] as the MSB byte.
//   The index is computed at WIDTH bits and wraps mod 2^WIDTH.
// - pop  = out_valid && out_ready.
// - push = !redirect && !fetch_fault && in_range && (occupancy < DEPTH || pop).
//   in_range means pc + 3 < ROM_SIZE.
// - On push: entry {pc, word} is written at the tail, and fetch PC <= pc + 4 (wraps mod 2^WIDTH).
//   When push is blocked, fetch PC holds.
// - Full with a simultaneous pop: push and pop both occur and occupancy stays DEPTH.
// - Empty with push: the entry becomes visible the next cycle. There is no bypass; fetch-to-out latency is 1 cycle.
// - Outputs come from registered FIFO storage and counters. There is no combinational path from inputs to outputs.
// - Redirect (rst=0):
//   - Queue emptied; occupancy <= 0.
//   - fetch PC <= {redirect_target[WIDTH-1:2], 2'b00}; fetch_fault <= 0.
//   - A pop in the same cycle still counts as consumed by decode. No push occurs that cycle.
//   - The first target entry is visible 2 cycles after the redirect edge: cycle 1 fetches, cycle 2 is valid.
// - Fault: if !in_range while not redirecting, fetch_fault <= 1 and fetch stops.
//   Entries already queued still drain normally.
//   The fault clears only on redirect or reset.
// - Pointers: head and tail are $clog2(DEPTH) bits wide and wrap naturally.
//   occupancy is tracked explicitly: +1 on push only, -1 on pop only, unchanged on both.
// - While out_valid=1 and out_ready=0, out_pc and out_instruction stay stable.
// TESTING
// - Reset release, RESET_PC=0, ROM words W0..W3, out_ready=0:
//   occupancy goes 1,2,3,4 and then holds 4. out_pc=0 / out_instruction=W0 stays stable. fetch PC holds at 16.
// - Full queue, out_ready=1 held:
//   one pop plus one push per cycle; occupancy stays 4; out_pc steps 0,4,8,12,16,... each cycle.
// - Redirect to 0x42 with occupancy 3, out_ready=1 in the same cycle:
//   occupancy becomes 0 the next cycle. After 2 cycles out_valid=1 and out_pc=0x40.
// - ROM_SIZE=32, sequential fetch:
//   the entry at pc=28 is queued; at pc=32 fetch_fault rises and no further push occurs.
//   The queue drains to empty, then a redirect to 0 clears the fault.
// - rst=1 together with redirect=1 while the queue is full:
//   all outputs are 0 the next cycle and the fetch PC restarts at RESET_PC (redirect ignored).
// - Random out_ready against a scoreboard of sequential PCs:
//   no entry is lost or duplicated, and occupancy never exceeds DEPTH.

Source files
------------

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch stage with a DEPTH-entry prefetch FIFO
module fetch_queue #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned BYTE     = 8,
    parameter int unsigned ROM_SIZE = 64,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [BYTE-1:0]              rom [0:ROM_SIZE-1],
    input  logic                         redirect,
    input  logic [WIDTH-1:0]             redirect_target,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_pc,
    output logic [WIDTH-1:0]             out_instruction,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic                         fetch_fault
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             fault_q, fault_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [WIDTH-1:0] mem_pc_q  [DEPTH];
    logic [WIDTH-1:0] mem_ins_q [DEPTH];

    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] idx;
    logic             in_range;
    logic             pop;
    logic             push;

    // The low target bits are forced to zero, so they are intentionally unused.
    logic unused_target_bits;
    assign unused_target_bits = ^redirect_target[1:0];

    // Big-endian word read: rom[pc] lands in the MSB byte; the index wraps at WIDTH bits.
    always_comb begin
        word = '0;
        idx  = '0;
        for (int b = 0; b < 4; b++) begin
            idx = pc_q + WIDTH'(b);
            for (int i = 0; i < int'(ROM_SIZE); i++) begin
                if (idx == WIDTH'(i)) begin
                    word[(3-b)*BYTE +: BYTE] = rom[i];
                end
            end
        end
    end

    // Range check is done one bit wider so pc + 3 cannot wrap back into range.
    assign in_range = ({1'b0, pc_q} + (WIDTH+1)'(3)) < (WIDTH+1)'(ROM_SIZE);

    assign out_valid       = (occ_q != '0);
    assign out_pc          = out_valid ? mem_pc_q[head_q]  : '0;
    assign out_instruction = out_valid ? mem_ins_q[head_q] : '0;
    assign occupancy       = occ_q;
    assign fetch_fault     = fault_q;

    assign pop  = out_valid && out_ready;
    assign push = !redirect && !fault_q && in_range && ((occ_q < OCC_W'(DEPTH)) || pop);

    // Next-state: redirect flushes and retargets; otherwise fetch, drain and fault tracking.
    always_comb begin
        pc_d    = pc_q;
        fault_d = fault_q;
        head_d  = head_q;
        tail_d  = tail_q;
        occ_d   = occ_q;
        if (redirect) begin
            pc_d    = {redirect_target[WIDTH-1:2], 2'b00};
            fault_d = 1'b0;
            head_d  = '0;
            tail_d  = '0;
            occ_d   = '0;
        end else begin
            if (!in_range) begin
                fault_d = 1'b1;
            end
            if (push) begin
                pc_d   = pc_q + WIDTH'(4);
                tail_d = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            if (push && !pop) begin
                occ_d = occ_q + OCC_W'(1);
            end else if (pop && !push) begin
                occ_d = occ_q - OCC_W'(1);
            end
        end
    end

    // Control state register; reset overrides redirect and everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= WIDTH'(RESET_PC);
            fault_q <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
            occ_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            fault_q <= fault_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            occ_q   <= occ_d;
        end
    end

    // Entry storage: write {pc, word} at the tail on every accepted fetch.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_pc_q[tail_q]  <= pc_q;
            mem_ins_q[tail_q] <= word;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue against a queue-based model
module tb_fetch_queue;

    localparam int ROM_SIZE = 96;
    localparam int DEPTH    = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        out_ready;
    logic [7:0]  rom [0:ROM_SIZE-1];
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instruction;
    logic [2:0]  occupancy;
    logic        fetch_fault;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] m_pc  [$];
    logic [31:0] m_ins [$];
    logic [31:0] m_fetch;
    bit          m_fault;

    always #5 clk = ~clk;

    fetch_queue #(
        .WIDTH(32), .BYTE(8), .ROM_SIZE(ROM_SIZE), .DEPTH(DEPTH), .RESET_PC(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rom(rom),
        .redirect(redirect),
        .redirect_target(redirect_target),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_pc(out_pc),
        .out_instruction(out_instruction),
        .occupancy(occupancy),
        .fetch_fault(fetch_fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        int i;
        i = int'(a);
        return {rom[i], rom[i+1], rom[i+2], rom[i+3]};
    endfunction

    // Reference behaviour for one rising edge, using the inputs present at that edge.
    task automatic model_edge();
        if (rst) begin
            m_pc.delete();
            m_ins.delete();
            m_fetch = 32'd0;
            m_fault = 1'b0;
        end else begin
            if (m_pc.size() > 0 && out_ready) begin
                void'(m_pc.pop_front());
                void'(m_ins.pop_front());
            end
            if (redirect) begin
                m_pc.delete();
                m_ins.delete();
                m_fetch = redirect_target & 32'hFFFF_FFFC;
                m_fault = 1'b0;
            end else if (m_fetch + 32'd3 >= 32'(ROM_SIZE)) begin
                m_fault = 1'b1;
            end else if (!m_fault && m_pc.size() < DEPTH) begin
                m_pc.push_back(m_fetch);
                m_ins.push_back(rom_word(m_fetch));
                m_fetch = m_fetch + 32'd4;
            end
        end
    endtask

    task automatic compare_all();
        logic [31:0] e_pc;
        logic [31:0] e_ins;
        e_pc  = (m_pc.size() > 0) ? m_pc[0]  : 32'd0;
        e_ins = (m_ins.size() > 0) ? m_ins[0] : 32'd0;
        chk("out_valid", 32'(out_valid), 32'(m_pc.size() > 0));
        chk("out_pc", out_pc, e_pc);
        chk("out_instruction", out_instruction, e_ins);
        chk("occupancy", 32'(occupancy), 32'(m_pc.size()));
        chk("fetch_fault", 32'(fetch_fault), 32'(m_fault));
        chk("occ_bound", 32'(occupancy <= 3'(DEPTH)), 32'd1);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        foreach (rom[i]) rom[i] = 8'($urandom);
        rst = 1'b1; redirect = 1'b0; redirect_target = 32'd0; out_ready = 1'b0;
        m_fetch = 32'd0; m_fault = 1'b0;
        cycle(); cycle();
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_occ", 32'(occupancy), 32'd0);

        // Fill with decode stalled: occupancy climbs to DEPTH and the head stays put.
        rst = 1'b0;
        repeat (6) cycle();
        chk("fill_occ", 32'(occupancy), 32'd4);
        chk("fill_head_pc", out_pc, 32'd0);
        chk("fill_head_ins", out_instruction, rom_word(32'd0));

        // Streaming while full: one pop and one push per cycle.
        out_ready = 1'b1;
        repeat (3) cycle();
        chk("stream_occ", 32'(occupancy), 32'd4);
        chk("stream_pc", out_pc, 32'd12);

        // Build occupancy 3, then redirect to 0x42 with a simultaneous pop.
        redirect = 1'b1; redirect_target = 32'h10;
        cycle();
        redirect = 1'b0; out_ready = 1'b0;
        repeat (3) cycle();
        chk("pre_redirect_occ", 32'(occupancy), 32'd3);
        redirect = 1'b1; redirect_target = 32'h42; out_ready = 1'b1;
        cycle();
        chk("redirect_occ", 32'(occupancy), 32'd0);
        redirect = 1'b0;
        cycle();
        chk("redirect_valid", 32'(out_valid), 32'd1);
        chk("redirect_pc", out_pc, 32'h40);

        // Run off the end of the ROM: 84, 88, 92 queue, 96 faults.
        redirect = 1'b1; redirect_target = 32'd84; out_ready = 1'b0;
        cycle();
        redirect = 1'b0;
        repeat (5) cycle();
        chk("fault_set", 32'(fetch_fault), 32'd1);
        chk("fault_occ", 32'(occupancy), 32'd3);
        out_ready = 1'b1;
        repeat (4) cycle();
        chk("fault_drained", 32'(occupancy), 32'd0);
        chk("fault_sticky", 32'(fetch_fault), 32'd1);
        redirect = 1'b1; redirect_target = 32'd0;
        cycle();
        chk("fault_cleared", 32'(fetch_fault), 32'd0);

        // Reset together with redirect while full.
        redirect = 1'b0; out_ready = 1'b0;
        repeat (5) cycle();
        rst = 1'b1; redirect = 1'b1; redirect_target = 32'h40;
        cycle();
        chk("rst_redir_valid", 32'(out_valid), 32'd0);
        chk("rst_redir_pc", out_pc, 32'd0);
        rst = 1'b0; redirect = 1'b0;
        cycle();
        chk("rst_restart_pc", out_pc, 32'd0);
        chk("rst_restart_valid", 32'(out_valid), 32'd1);

        // Randomised traffic against the model.
        repeat (800) begin
            out_ready       = 1'($urandom_range(0, 1));
            redirect        = ($urandom_range(0, 19) == 0);
            redirect_target = 32'($urandom_range(0, 127));
            rst             = ($urandom_range(0, 199) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
